// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t      - byte receiver FSM states
//   UART_OVERSAMPLE - default clken ticks per bit period
//   UART_DATA_BITS  - data bits per 8N1 frame
//   UART_WORD_BYTES - bytes assembled into one output word
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   localparam int unsigned UART_OVERSAMPLE = 16;
   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_WORD_BYTES = 4;

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte deserialiser with 2-flop input synchroniser.
//   i_clk, i_rst   - system clock, async active-high reset
//   i_clken        - single-cycle pulse at OVERSAMPLE x baud
//   i_rx           - asynchronous serial line, idle high
//   o_byte_valid   - one-cycle pulse: o_byte_data holds a byte with a good stop bit
//   o_byte_data    - received byte (LSB first on the line)
//   o_frame_err    - one-cycle pulse: stop bit sampled low
//   o_start        - one-cycle pulse: falling edge seen in IDLE
//   o_busy         - FSM is not in IDLE
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_clken,
   input  logic                      i_rx,
   output logic                      o_byte_valid,
   output logic [UART_DATA_BITS-1:0] o_byte_data,
   output logic                      o_frame_err,
   output logic                      o_start,
   output logic                      o_busy
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

   rx_state_t                 r_state, w_state_next;
   logic [CNT_W-1:0]          r_cnt, w_cnt_next;
   logic [BIT_W-1:0]          r_bit_idx, w_bit_idx_next;
   logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
   logic                      r_rx_meta, r_rx_s;

   // Synchroniser resets to the idle (high) line level so reset never fakes a start bit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      o_byte_valid   = 1'b0;
      o_frame_err    = 1'b0;
      o_start        = 1'b0;
      if (i_clken) begin
         case (r_state)
            IDLE: begin
               if (!r_rx_s) begin
                  w_state_next = START;
                  w_cnt_next   = '0;
                  o_start      = 1'b1;
               end
            end
            START: begin
               if (r_cnt == HALF_LAST) begin
                  // Line back high at mid start bit: a glitch, not a frame.
                  w_state_next   = r_rx_s ? IDLE : DATA;
                  w_cnt_next     = '0;
                  w_bit_idx_next = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (r_cnt == FULL_LAST) begin
                  w_cnt_next     = '0;
                  w_shift_next   = {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
                  w_bit_idx_next = r_bit_idx + 1'b1;
                  if (r_bit_idx == BIT_LAST) begin
                     w_state_next = STOP;
                  end
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            STOP: begin
               if (r_cnt == FULL_LAST) begin
                  w_cnt_next   = '0;
                  w_state_next = IDLE;
                  o_byte_valid = r_rx_s;
                  o_frame_err  = !r_rx_s;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   assign o_byte_data = r_shift;
   assign o_busy      = (r_state != IDLE);

endmodule

// File: rtl/uart_word_receiver.sv
// uart_word_receiver: assembles four 8N1 bytes into a little-endian 32-bit word.
//   clk_50m  - system clock
//   rst      - asynchronous active-high reset
//   clken    - single-cycle pulse at OVERSAMPLE x baud
//   Rx       - serial line, asynchronous, idle high
//   rdy_clr  - pulse: consumer has taken data_out
//   data_out - last complete word (first byte received in [7:0])
//   rdy      - data_out valid and unread
//   frm_err  - one-cycle pulse on bad stop bit
//   ovr      - sticky: a word was overwritten while rdy=1
//   Rx_busy  - byte receiver not idle
module uart_word_receiver
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE   = UART_OVERSAMPLE,
   parameter int unsigned WORD_BYTES   = UART_WORD_BYTES,
   parameter int unsigned TIMEOUT_BITS = 32
) (
   input  logic        clk_50m,
   input  logic        rst,
   input  logic        clken,
   input  logic        Rx,
   input  logic        rdy_clr,
   output logic [31:0] data_out,
   output logic        rdy,
   output logic        frm_err,
   output logic        ovr,
   output logic        Rx_busy
);

   localparam int unsigned IDX_W    = $clog2(WORD_BYTES);
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

   logic             w_byte_valid, w_frame_err, w_start, w_busy;
   logic [7:0]       w_byte_data;
   logic [31:0]      w_word;
   logic             w_word_done, w_to_hit;
   logic [IDX_W-1:0] r_byte_idx;
   logic [TO_W-1:0]  r_to_cnt;
   logic [31:0]      r_word_buf, r_data_out;
   logic             r_rdy, r_ovr;

   uart_byte_rx #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_byte_rx (
      .i_clk        (clk_50m),
      .i_rst        (rst),
      .i_clken      (clken),
      .i_rx         (Rx),
      .o_byte_valid (w_byte_valid),
      .o_byte_data  (w_byte_data),
      .o_frame_err  (w_frame_err),
      .o_start      (w_start),
      .o_busy       (w_busy)
   );

   // Assembly buffer with the incoming byte already merged into its lane, so a
   // completing byte can be published on the same edge it is accepted.
   always_comb begin
      w_word = r_word_buf;
      w_word[{r_byte_idx, 3'b000} +: 8] = w_byte_data;
   end

   assign w_word_done = w_byte_valid && (r_byte_idx == IDX_W'(WORD_BYTES - 1));
   assign w_to_hit    = clken && !w_busy && (r_byte_idx != '0) &&
                        (r_to_cnt == TO_W'(TO_LIMIT - 1));

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         r_byte_idx <= '0;
         r_to_cnt   <= '0;
         r_word_buf <= '0;
         r_data_out <= '0;
         r_rdy      <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         if (w_byte_valid) begin
            r_word_buf <= w_word;
            r_byte_idx <= w_word_done ? '0 : r_byte_idx + 1'b1;
         end else if (w_frame_err || w_to_hit) begin
            r_byte_idx <= '0;
         end

         // Inter-byte idle timer: only runs between bytes of a partial word.
         if (w_start || w_byte_valid || w_frame_err || w_to_hit || (r_byte_idx == '0)) begin
            r_to_cnt <= '0;
         end else if (clken && !w_busy) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end

         // Completion beats a simultaneous rdy_clr; that clr still wipes ovr.
         if (w_word_done) begin
            r_data_out <= w_word;
            r_rdy      <= 1'b1;
            if (rdy_clr) begin
               r_ovr <= 1'b0;
            end else if (r_rdy) begin
               r_ovr <= 1'b1;
            end
         end else if (rdy_clr && r_rdy) begin
            r_rdy <= 1'b0;
            r_ovr <= 1'b0;
         end
      end
   end

   assign data_out = r_data_out;
   assign rdy      = r_rdy;
   assign ovr      = r_ovr;
   assign frm_err  = w_frame_err;
   assign Rx_busy  = w_busy;

endmodule

// File: tb/tb_uart_word_receiver.sv
// tb_uart_word_receiver: self-checking bench for uart_word_receiver.
// Drives 8N1 frames at 16 clken ticks per bit (clken every 4 clocks) and checks
// outputs against a byte-queue model of the word assembly and handshake rules.
module tb_uart_word_receiver;

   localparam int CLK_PER_TICK = 4;
   localparam int OS           = 16;
   localparam int BIT_CLKS     = CLK_PER_TICK * OS;
   localparam int TO_BITS      = 32;

   logic        clk_50m = 1'b0;
   logic        rst     = 1'b1;
   logic        clken   = 1'b0;
   logic        Rx      = 1'b1;
   logic        rdy_clr = 1'b0;
   logic [31:0] data_out;
   logic        rdy, frm_err, ovr, Rx_busy;

   int n_checks = 0;
   int n_errors = 0;
   int frm_cnt  = 0;

   // Reference model state
   logic [7:0]  m_bytes[$];
   logic [31:0] m_word = '0;
   logic        m_rdy  = 1'b0;
   logic        m_ovr  = 1'b0;

   uart_word_receiver #(
      .OVERSAMPLE   (OS),
      .WORD_BYTES   (4),
      .TIMEOUT_BITS (TO_BITS)
   ) dut (
      .clk_50m  (clk_50m),
      .rst      (rst),
      .clken    (clken),
      .Rx       (Rx),
      .rdy_clr  (rdy_clr),
      .data_out (data_out),
      .rdy      (rdy),
      .frm_err  (frm_err),
      .ovr      (ovr),
      .Rx_busy  (Rx_busy)
   );

   always #5 clk_50m = ~clk_50m;

   initial begin
      forever begin
         repeat (CLK_PER_TICK - 1) @(negedge clk_50m);
         clken = 1'b1;
         @(negedge clk_50m);
         clken = 1'b0;
      end
   end

   always @(posedge clk_50m) begin
      if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;
   end

   task automatic m_push(input logic [7:0] b);
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
         m_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
         if (m_rdy) m_ovr = 1'b1;
         m_rdy = 1'b1;
         m_bytes.delete();
      end
   endtask

   task automatic hold(input int clks);
      repeat (clks) @(negedge clk_50m);
   endtask

   // One 8N1 frame, two stop bits when good; a bad stop is a short low then idle.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      Rx = 1'b0;
      hold(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         Rx = b[i];
         hold(BIT_CLKS);
      end
      if (stop_ok) begin
         Rx = 1'b1;
         hold(2 * BIT_CLKS);
         m_push(b);
      end else begin
         Rx = 1'b0;
         hold(12 * CLK_PER_TICK);
         Rx = 1'b1;
         hold(2 * BIT_CLKS);
         m_bytes.delete();
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
   endtask

   task automatic idle_bits(input int n);
      Rx = 1'b1;
      hold(n * BIT_CLKS);
      if (n >= TO_BITS) m_bytes.delete();
   endtask

   task automatic pulse_clr();
      rdy_clr = 1'b1;
      @(negedge clk_50m);
      rdy_clr = 1'b0;
      if (m_rdy) begin
         m_rdy = 1'b0;
         m_ovr = 1'b0;
      end
      @(negedge clk_50m);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk_50m);
      #1;
      n_checks++; if (data_out !== 32'h0) begin n_errors++; $display("FAIL reset_data got %h want 0", data_out); end
      n_checks++; if (rdy !== 1'b0) begin n_errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
      n_checks++; if (frm_err !== 1'b0) begin n_errors++; $display("FAIL reset_frm got %b want 0", frm_err); end
      n_checks++; if (ovr !== 1'b0) begin n_errors++; $display("FAIL reset_ovr got %b want 0", ovr); end
      n_checks++; if (Rx_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", Rx_busy); end
      rst = 1'b0;
      hold(4);
   endtask

   task automatic test_basic();
      int f0;
      f0 = frm_cnt;
      send_word(32'hDEADBEEF);
      #1;
      n_checks++; if (data_out !== m_word) begin n_errors++; $display("FAIL basic_data got %h want %h", data_out, m_word); end
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL basic_rdy got %b want %b", rdy, m_rdy); end
      n_checks++; if (ovr !== m_ovr) begin n_errors++; $display("FAIL basic_ovr got %b want %b", ovr, m_ovr); end
      n_checks++; if (frm_cnt != f0) begin n_errors++; $display("FAIL basic_frm got %0d pulses want 0", frm_cnt - f0); end
      pulse_clr();
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL basic_clr_rdy got %b want %b", rdy, m_rdy); end
   endtask

   task automatic test_false_start();
      int waited;
      Rx = 1'b0;
      hold(4 * CLK_PER_TICK);
      #1;
      n_checks++; if (Rx_busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_rise got %b want 1", Rx_busy); end
      Rx = 1'b1;
      waited = 0;
      while (Rx_busy === 1'b1 && waited < 8 * CLK_PER_TICK) begin
         @(negedge clk_50m);
         waited++;
      end
      #1;
      n_checks++; if (Rx_busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_fall got %b want 0 after %0d clks", Rx_busy, waited); end
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL glitch_rdy got %b want %b", rdy, m_rdy); end
      idle_bits(2);
      send_word(32'h01234567);
      #1;
      n_checks++; if (data_out !== m_word) begin n_errors++; $display("FAIL glitch_data got %h want %h", data_out, m_word); end
      pulse_clr();
   endtask

   task automatic test_frame_err();
      int f0;
      f0 = frm_cnt;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      n_checks++; if (frm_cnt - f0 != 1) begin n_errors++; $display("FAIL frm_pulse got %0d cycles want 1", frm_cnt - f0); end
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL frm_rdy got %b want %b", rdy, m_rdy); end
      send_word(32'h77665544);
      #1;
      n_checks++; if (data_out !== m_word) begin n_errors++; $display("FAIL frm_data got %h want %h", data_out, m_word); end
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL frm_rdy2 got %b want %b", rdy, m_rdy); end
      pulse_clr();
   endtask

   task automatic test_overrun();
      send_word(32'hA5A5A5A5);
      send_word(32'h5A5A5A5A);
      #1;
      n_checks++; if (data_out !== m_word) begin n_errors++; $display("FAIL ovr_data got %h want %h", data_out, m_word); end
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL ovr_rdy got %b want %b", rdy, m_rdy); end
      n_checks++; if (ovr !== m_ovr) begin n_errors++; $display("FAIL ovr_flag got %b want %b", ovr, m_ovr); end
      pulse_clr();
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL ovr_clr_rdy got %b want %b", rdy, m_rdy); end
      n_checks++; if (ovr !== m_ovr) begin n_errors++; $display("FAIL ovr_clr_flag got %b want %b", ovr, m_ovr); end
   endtask

   task automatic test_timeout();
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      idle_bits(40);
      send_word(32'h04030201);
      #1;
      n_checks++; if (data_out !== m_word) begin n_errors++; $display("FAIL timeout_data got %h want %h", data_out, m_word); end
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL timeout_rdy got %b want %b", rdy, m_rdy); end
      pulse_clr();
   endtask

   task automatic test_random();
      logic [31:0] w;
      for (int k = 0; k < 3; k++) begin
         w = $urandom;
         for (int i = 0; i < 4; i++) begin
            send_byte(w[i*8 +: 8], 1'b1);
            idle_bits($urandom_range(0, 4));
         end
         #1;
         n_checks++; if (data_out !== m_word) begin n_errors++; $display("FAIL rand%0d_data got %h want %h", k, data_out, m_word); end
         n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL rand%0d_rdy got %b want %b", k, rdy, m_rdy); end
         n_checks++; if (ovr !== m_ovr) begin n_errors++; $display("FAIL rand%0d_ovr got %b want %b", k, ovr, m_ovr); end
         if ($urandom_range(0, 1) == 1) pulse_clr();
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      send_word($urandom);
      send_word($urandom);
      #1;
      n_checks++; if (ovr !== m_ovr) begin n_errors++; $display("FAIL rstmid_pre_ovr got %b want %b", ovr, m_ovr); end
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      b = 8'h56;
      Rx = 1'b0;
      hold(BIT_CLKS);
      for (int i = 0; i < 3; i++) begin
         Rx = b[i];
         hold(BIT_CLKS);
      end
      hold(30);
      #1;
      rst = 1'b1;
      Rx  = 1'b1;
      m_bytes.delete();
      m_word = '0;
      m_rdy  = 1'b0;
      m_ovr  = 1'b0;
      #1;
      n_checks++; if (data_out !== m_word) begin n_errors++; $display("FAIL rstmid_data got %h want %h", data_out, m_word); end
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL rstmid_rdy got %b want %b", rdy, m_rdy); end
      n_checks++; if (ovr !== m_ovr) begin n_errors++; $display("FAIL rstmid_ovr got %b want %b", ovr, m_ovr); end
      n_checks++; if (Rx_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b want 0", Rx_busy); end
      n_checks++; if (frm_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_frm got %b want 0", frm_err); end
      hold(3);
      rst = 1'b0;
      idle_bits(2);
      send_word(32'hCAFEF00D);
      #1;
      n_checks++; if (data_out !== m_word) begin n_errors++; $display("FAIL rstmid_word got %h want %h", data_out, m_word); end
      n_checks++; if (rdy !== m_rdy) begin n_errors++; $display("FAIL rstmid_word_rdy got %b want %b", rdy, m_rdy); end
      n_checks++; if (ovr !== m_ovr) begin n_errors++; $display("FAIL rstmid_word_ovr got %b want %b", ovr, m_ovr); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
